// File: rtl/shadow_capture_chain.sv
// Debug shadow capture: snapshots host flop groups and shifts the frozen snapshot out on
// one or more serial chains, optionally followed by the data of upstream chains.
module shadow_capture_chain #(
    parameter int unsigned                     DFF_BITS      = 4,
    parameter int unsigned                     USE_DCLK      = 1,
    parameter int unsigned                     CHAINS_IN     = 0,
    parameter int unsigned                     CHAINS_OUT    = 1,
    parameter int unsigned                     DISCRETE_DFFS = 1,
    parameter logic [DISCRETE_DFFS*32-1:0]     DFF_WIDTHS    = {32'd4}
) (
    input  logic                                           i_clk,
    input  logic                                           i_rst,
    input  logic                                           i_capture_en,
    input  logic [DISCRETE_DFFS-1:0]                       i_dclk,
    input  logic [DFF_BITS-1:0]                            i_din,
    input  logic [CHAINS_OUT-1:0]                          i_dump_en,
    input  logic [((CHAINS_IN > 0) ? CHAINS_IN : 1)-1:0]   i_chains_in,
    input  logic [((CHAINS_IN > 0) ? CHAINS_IN : 1)-1:0]   i_chains_in_vld,
    input  logic [((CHAINS_IN > 0) ? CHAINS_IN : 1)-1:0]   i_chains_in_done,
    output logic [((CHAINS_IN > 0) ? CHAINS_IN : 1)-1:0]   o_chain_dump_en,
    output logic [CHAINS_OUT-1:0]                          o_chains_out,
    output logic [CHAINS_OUT-1:0]                          o_chains_out_vld,
    output logic [CHAINS_OUT-1:0]                          o_chains_out_done
);

    localparam bit          HasIn = (CHAINS_IN > 0);
    localparam int unsigned CntW  = (DFF_BITS > 1) ? $clog2(DFF_BITS) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StFwd, StDone} state_e;

    // Lowest snapshot bit owned by capture group k.
    function automatic int unsigned grp_lo(input int unsigned k);
        int unsigned s;
        s = 0;
        for (int unsigned m = 0; m < DISCRETE_DFFS; m++) begin
            if (m < k) s += DFF_WIDTHS[32*m +: 32];
        end
        return s;
    endfunction

    logic [DISCRETE_DFFS-1:0] r_dclk_q;
    logic [DISCRETE_DFFS-1:0] w_grp_cap;
    logic [DFF_BITS-1:0]      r_snap;
    logic [DFF_BITS-1:0]      w_load;
    logic [CHAINS_OUT-1:0]    r_dump_q;
    logic [CHAINS_OUT-1:0]    w_busy;
    logic [CHAINS_OUT-1:0]    w_req_vec;
    logic                     w_frozen;

    assign w_frozen = |w_busy;

    always_comb begin
        w_grp_cap = '0;
        for (int unsigned k = 0; k < DISCRETE_DFFS; k++) begin
            w_grp_cap[k] = i_capture_en & ~w_frozen &
                           ((USE_DCLK == 0) | (i_dclk[k] & ~r_dclk_q[k]));
        end
    end

    always_comb begin
        w_load = '0;
        for (int unsigned k = 0; k < DISCRETE_DFFS; k++) begin
            for (int unsigned b = 0; b < DFF_BITS; b++) begin
                if (b >= grp_lo(k) && b < grp_lo(k + 1)) w_load[b] = w_grp_cap[k];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dclk_q <= '0;
            r_dump_q <= '0;
            r_snap   <= '0;
        end else begin
            r_dclk_q <= i_dclk;
            r_dump_q <= i_dump_en;
            r_snap   <= (r_snap & ~w_load) | (i_din & w_load);
        end
    end

    genvar j;
    for (j = 0; j < CHAINS_OUT; j++) begin : g_chain
        // Chain j owns snapshot bits j, j+CHAINS_OUT, j+2*CHAINS_OUT, ...
        localparam int unsigned    LocalN  = (j < DFF_BITS) ?
                                             (DFF_BITS - j + CHAINS_OUT - 1) / CHAINS_OUT : 0;
        localparam logic [CntW-1:0] LastCnt = CntW'((LocalN > 0) ? LocalN - 1 : 0);

        state_e                 r_state, w_state_d;
        logic [CntW-1:0]        r_cnt, w_cnt_d;
        logic [(1<<CntW)-1:0]   w_local;
        logic                   w_rise;
        logic                   w_in, w_in_vld, w_in_done;
        logic                   w_out_d, w_vld_d, w_done_d, w_req_d;
        logic                   r_out, r_vld, r_done, r_req;

        assign w_rise = i_dump_en[j] & ~r_dump_q[j];

        if (HasIn) begin : g_in
            assign w_in      = i_chains_in[j];
            assign w_in_vld  = i_chains_in_vld[j];
            assign w_in_done = i_chains_in_done[j];
        end else begin : g_no_in
            assign w_in      = 1'b0;
            assign w_in_vld  = 1'b0;
            assign w_in_done = 1'b0;
        end

        always_comb begin
            w_local = '0;
            for (int unsigned n = 0; n < LocalN; n++) begin
                w_local[n] = r_snap[n * CHAINS_OUT + j];
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_state <= StIdle;
                r_cnt   <= '0;
                r_out   <= 1'b0;
                r_vld   <= 1'b0;
                r_done  <= 1'b0;
                r_req   <= 1'b0;
            end else begin
                r_state <= w_state_d;
                r_cnt   <= w_cnt_d;
                r_out   <= w_out_d;
                r_vld   <= w_vld_d;
                r_done  <= w_done_d;
                r_req   <= w_req_d;
            end
        end

        always_comb begin
            w_state_d = r_state;
            unique case (r_state)
                StIdle:  if (w_rise) w_state_d = StShift;
                StShift: if (LocalN == 0 || r_cnt == LastCnt) w_state_d = HasIn ? StFwd : StDone;
                StFwd:   if (w_in_done) w_state_d = StDone;
                StDone:  w_state_d = StIdle;
                default: w_state_d = StIdle;
            endcase
        end

        always_comb begin
            w_cnt_d  = '0;
            w_out_d  = 1'b0;
            w_vld_d  = 1'b0;
            w_done_d = 1'b0;
            w_req_d  = 1'b0;
            unique case (r_state)
                StShift: begin
                    if (LocalN != 0) begin
                        w_out_d = w_local[r_cnt];
                        w_vld_d = 1'b1;
                        w_cnt_d = r_cnt + 1'b1;
                    end
                    w_req_d = (w_state_d == StFwd);
                end
                StFwd: begin
                    w_out_d = w_in;
                    w_vld_d = w_in_vld;
                end
                StDone:  w_done_d = 1'b1;
                default: ;
            endcase
        end

        assign w_busy[j]            = (r_state != StIdle);
        assign w_req_vec[j]         = r_req;
        assign o_chains_out[j]      = r_out;
        assign o_chains_out_vld[j]  = r_vld;
        assign o_chains_out_done[j] = r_done;
    end

    if (HasIn) begin : g_req
        assign o_chain_dump_en = w_req_vec;
    end else begin : g_no_req
        logic w_unused_chains_in;
        assign o_chain_dump_en    = '0;
        assign w_unused_chains_in = ^{i_chains_in, i_chains_in_vld, i_chains_in_done, w_req_vec};
    end

endmodule

// File: tb/tb_shadow_capture_chain.sv
// Directed bench for shadow_capture_chain: default, forwarding and two-group instances.
module tb_shadow_capture_chain;

    logic       clk = 1'b0;
    logic       rst, cap_en, dump_en, dump1;
    logic [3:0] din0, din1, din2;
    logic       dclk0, dclk1;
    logic [1:0] dclk2;
    logic       up_in, up_vld, up_done;

    logic o0_cde, o0_out, o0_vld, o0_done;
    logic o1_cde, o1_out, o1_vld, o1_done;
    logic o2_cde, o2_out, o2_vld, o2_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shadow_capture_chain u0 (
        .i_clk(clk), .i_rst(rst), .i_capture_en(cap_en), .i_dclk(dclk0), .i_din(din0),
        .i_dump_en(dump_en), .i_chains_in(1'b0), .i_chains_in_vld(1'b0),
        .i_chains_in_done(1'b0), .o_chain_dump_en(o0_cde), .o_chains_out(o0_out),
        .o_chains_out_vld(o0_vld), .o_chains_out_done(o0_done)
    );

    shadow_capture_chain #(.CHAINS_IN(1), .CHAINS_OUT(1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_capture_en(cap_en), .i_dclk(dclk1), .i_din(din1),
        .i_dump_en(dump1), .i_chains_in(up_in), .i_chains_in_vld(up_vld),
        .i_chains_in_done(up_done), .o_chain_dump_en(o1_cde), .o_chains_out(o1_out),
        .o_chains_out_vld(o1_vld), .o_chains_out_done(o1_done)
    );

    shadow_capture_chain #(.DISCRETE_DFFS(2), .DFF_WIDTHS({32'd2, 32'd2})) u2 (
        .i_clk(clk), .i_rst(rst), .i_capture_en(cap_en), .i_dclk(dclk2), .i_din(din2),
        .i_dump_en(dump_en), .i_chains_in(1'b0), .i_chains_in_vld(1'b0),
        .i_chains_in_done(1'b0), .o_chain_dump_en(o2_cde), .o_chains_out(o2_out),
        .o_chains_out_vld(o2_vld), .o_chains_out_done(o2_done)
    );

    // Observed vector: {chain_dump_en, done, vld, out}
    function automatic logic [3:0] obs(input int sel);
        case (sel)
            0:       return {o0_cde, o0_done, o0_vld, o0_out};
            1:       return {o1_cde, o1_done, o1_vld, o1_out};
            default: return {o2_cde, o2_done, o2_vld, o2_out};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Dump a 4-bit local chain; optionally disturb din0/dclk0 while the chain is busy.
    task automatic run_dump(input int sel, input logic [3:0] bits, input bit wiggle,
                            input string tag);
        dump_en = 1'b1;
        tick();
        chk({tag, "_e0"}, obs(sel), 4'b0000);
        for (int n = 0; n < 4; n++) begin
            if (wiggle) begin
                dclk0 = (n % 2 == 0);
                din0  = ~din0;
            end
            tick();
            chk({tag, "_bit"}, obs(sel), {3'b001, bits[n]});
        end
        tick();
        chk({tag, "_done"}, obs(sel), 4'b0100);
        tick();
        chk({tag, "_held"}, obs(sel), 4'b0000);
        tick();
        chk({tag, "_held2"}, obs(sel), 4'b0000);
        dump_en = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0; cap_en = 1'b0; dump_en = 1'b0; dump1 = 1'b0;
        din0 = '0; din1 = '0; din2 = '0; dclk0 = 1'b0; dclk1 = 1'b0; dclk2 = '0;
        up_in = 1'b0; up_vld = 1'b0; up_done = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_u0", obs(0), 4'b0000);
        chk("rst_u1", obs(1), 4'b0000);
        chk("rst_u2", obs(2), 4'b0000);
        tick(); tick();
        rst = 1'b0;
        tick();

        din0 = 4'b1011; cap_en = 1'b1; dclk0 = 1'b1;
        tick(); tick();
        dclk0 = 1'b0;
        tick(); tick();
        run_dump(0, 4'b1011, 1'b0, "cap");

        cap_en = 1'b0; din0 = 4'b0110; dclk0 = 1'b1;
        tick(); tick();
        dclk0 = 1'b0;
        tick();
        run_dump(0, 4'b1011, 1'b0, "noen");

        cap_en = 1'b1; din0 = 4'b0000;
        run_dump(0, 4'b1011, 1'b1, "frz");

        din0 = 4'b0110; dclk0 = 1'b1;
        tick(); tick();
        dclk0 = 1'b0;
        tick();
        dump_en = 1'b1;
        tick(); tick(); tick();
        chk("pre_rst_bit1", obs(0), 4'b0011);
        #2 rst = 1'b1; dump_en = 1'b0;
        #1;
        chk("rst_mid", obs(0), 4'b0000);
        tick();
        rst = 1'b0;
        tick();
        run_dump(0, 4'b0000, 1'b0, "post_rst");

        din1 = 4'b0001; dclk1 = 1'b1;
        tick(); tick();
        dclk1 = 1'b0;
        tick();
        dump1 = 1'b1;
        tick();
        chk("fwd_e0", obs(1), 4'b0000);
        tick(); chk("fwd_b0", obs(1), 4'b0011);
        tick(); chk("fwd_b1", obs(1), 4'b0010);
        tick(); chk("fwd_b2", obs(1), 4'b0010);
        tick(); chk("fwd_b3_req", obs(1), 4'b1010);
        up_in = 1'b1; up_vld = 1'b1;
        tick(); chk("fwd_up0", obs(1), 4'b0011);
        up_in = 1'b0; up_vld = 1'b1;
        tick(); chk("fwd_up1", obs(1), 4'b0010);
        up_vld = 1'b0; up_done = 1'b1;
        tick(); chk("fwd_updone", obs(1), 4'b0000);
        up_done = 1'b0;
        tick(); chk("fwd_done", obs(1), 4'b0100);
        tick(); chk("fwd_idle", obs(1), 4'b0000);
        dump1 = 1'b0;
        tick();

        din2 = 4'b1111; dclk2 = 2'b11;
        tick(); tick();
        dclk2 = 2'b00;
        tick();
        din2 = 4'b0000; dclk2 = 2'b10;
        tick(); tick();
        dclk2 = 2'b00;
        tick();
        run_dump(2, 4'b0011, 1'b0, "grp_hi");

        din2 = 4'b1110; dclk2 = 2'b01;
        tick(); tick();
        dclk2 = 2'b00;
        tick();
        run_dump(2, 4'b0010, 1'b0, "grp_lo");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
